// File: rtl/seq_booth_multiplier.sv
// Sequential radix-2 Booth multiplier: one add/sub-and-shift step per cycle, start/done handshake,
// signed or unsigned operands selected at elaboration.
module seq_booth_multiplier #(
    parameter int unsigned WIDTH  = 32,
    parameter bit          SIGNED = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    // Unsigned operands get one extra bit so the Booth recoding sees a zero sign bit.
    localparam int unsigned N  = SIGNED ? WIDTH : WIDTH + 1;
    localparam int unsigned CW = $clog2(N + 1);
    localparam int unsigned PW = 2 * WIDTH;

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e state_q, state_d;

    logic [N:0]     m_q, acc_q;
    logic [N-1:0]   q_q;
    logic           qm1_q;
    logic [CW-1:0]  cnt_q;
    logic [PW-1:0]  product_q;

    logic [N:0]     a_ext, b_ext;
    logic [N:0]     sum;
    logic [N:0]     acc_sh;
    logic [N-1:0]   q_sh;
    logic [PW-1:0]  prod_nx;
    logic           accept;

    assign a_ext = {{(N + 1 - WIDTH){SIGNED && a[WIDTH-1]}}, a};
    assign b_ext = {{(N + 1 - WIDTH){SIGNED && b[WIDTH-1]}}, b};

    assign accept = start && (state_q != StCalc);

    always_comb begin
        unique case ({q_q[0], qm1_q})
            2'b01:   sum = acc_q + m_q;
            2'b10:   sum = acc_q - m_q;
            default: sum = acc_q;
        endcase
    end

    assign acc_sh  = {sum[N], sum[N:1]};
    assign q_sh    = {sum[0], q_q[N-1:1]};
    assign prod_nx = PW'({acc_sh, q_sh});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (start) state_d = StCalc;
            StCalc: if (cnt_q == CW'(1)) state_d = StDone;
            StDone: state_d = start ? StCalc : StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy    = (state_q == StCalc);
        done    = (state_q == StDone);
        product = product_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q       <= '0;
            acc_q     <= '0;
            q_q       <= '0;
            qm1_q     <= 1'b0;
            cnt_q     <= '0;
            product_q <= '0;
        end else if (accept) begin
            m_q   <= a_ext;
            acc_q <= '0;
            q_q   <= b_ext[N-1:0];
            qm1_q <= 1'b0;
            cnt_q <= CW'(N);
        end else if (state_q == StCalc) begin
            acc_q <= acc_sh;
            q_q   <= q_sh;
            qm1_q <= q_q[0];
            cnt_q <= cnt_q - 1'b1;
            // Final step: capture the product as the FSM enters StDone.
            if (cnt_q == CW'(1)) begin
                product_q <= prod_nx;
            end
        end
    end

endmodule
